phase_sequencer: RTL

- Top-level controller for the adaptive-threshold pipeline.
- Sequences the two processing phases, box filter then threshold, with start/done handshakes.
- Arbitrates the single image ROM address port between the two phases.
- Latches the threshold offset C and guards each phase with a watchdog.
- Drives LED status and a completed-frame counter; sits between the switch/reset inputs and the box_filter/threshold engines.

---
 rtl/phase_pkg.sv | 50 +++++
 rtl/phase_sequencer_if.sv | 33 +++
 rtl/phase_watchdog.sv | 30 +++
 rtl/phase_sequencer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/phase_pkg.sv
// Shared constants for the adaptive-threshold phase sequencer: state codes,
// LED status codes, default widths and small state-classification helpers.
package phase_pkg;

    localparam int DEFAULT_WIDTH_BITS   = 8;
    localparam int DEFAULT_HEIGHT_BITS  = 8;
    localparam int DEFAULT_C_BITS       = 5;
    localparam int DEFAULT_TIMEOUT_BITS = 20;

    typedef logic [2:0] phaseState_t;

    localparam phaseState_t STATE_IDLE      = 3'd0;
    localparam phaseState_t STATE_BOX_START = 3'd1;
    localparam phaseState_t STATE_BOX_RUN   = 3'd2;
    localparam phaseState_t STATE_THR_START = 3'd3;
    localparam phaseState_t STATE_THR_RUN   = 3'd4;
    localparam phaseState_t STATE_DONE      = 3'd5;
    localparam phaseState_t STATE_ERROR     = 3'd6;

    localparam logic [4:0] LED_IDLE  = 5'b00001;
    localparam logic [4:0] LED_BOX   = 5'b00010;
    localparam logic [4:0] LED_THR   = 5'b00100;
    localparam logic [4:0] LED_DONE  = 5'b01000;
    localparam logic [4:0] LED_ERROR = 5'b10000;

    // The unused encoding shows as IDLE since the FSM leaves it on the next edge.
    function automatic logic [4:0] ledStatus(input phaseState_t state);
        case (state)
            STATE_BOX_START, STATE_BOX_RUN: ledStatus = LED_BOX;
            STATE_THR_START, STATE_THR_RUN: ledStatus = LED_THR;
            STATE_DONE:                     ledStatus = LED_DONE;
            STATE_ERROR:                    ledStatus = LED_ERROR;
            default:                        ledStatus = LED_IDLE;
        endcase
    endfunction

    function automatic logic isActive(input phaseState_t state);
        return (state == STATE_BOX_START) || (state == STATE_BOX_RUN) ||
               (state == STATE_THR_START) || (state == STATE_THR_RUN);
    endfunction

    function automatic logic isRunState(input phaseState_t state);
        return (state == STATE_BOX_RUN) || (state == STATE_THR_RUN);
    endfunction

    function automatic logic isThrPhase(input phaseState_t state);
        return (state == STATE_THR_START) || (state == STATE_THR_RUN);
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Engine-facing bundle of the phase sequencer: start/done handshakes for the
// box filter and threshold engines plus the shared image ROM address port.
interface phase_sequencer_if
    import phase_pkg::*;
#(
    parameter int WIDTH_BITS  = DEFAULT_WIDTH_BITS,
    parameter int HEIGHT_BITS = DEFAULT_HEIGHT_BITS
);

    logic                   oBoxStart;
    logic                   iBoxDone;
    logic                   oThrStart;
    logic                   iThrDone;
    logic [WIDTH_BITS-1:0]  iBoxCol;
    logic [HEIGHT_BITS-1:0] iBoxRow;
    logic [WIDTH_BITS-1:0]  iThrCol;
    logic [HEIGHT_BITS-1:0] iThrRow;
    logic [WIDTH_BITS-1:0]  oImageCol;
    logic [HEIGHT_BITS-1:0] oImageRow;

    // Sequencer side: issues starts and owns the arbitrated ROM address.
    modport master (
        output oBoxStart, oThrStart, oImageCol, oImageRow,
        input  iBoxDone, iThrDone, iBoxCol, iBoxRow, iThrCol, iThrRow
    );

    // Engine side: reports completion and presents its requested address.
    modport slave (
        input  oBoxStart, oThrStart, oImageCol, oImageRow,
        output iBoxDone, iThrDone, iBoxCol, iBoxRow, iThrCol, iThrRow
    );

endinterface

// File: rtl/phase_watchdog.sv
// Per-phase watchdog: counts cycles while enabled and flags the last allowed
// cycle, so a phase may stay in its RUN state for 2**TIMEOUT_BITS-1 cycles.
module phase_watchdog #(
    parameter int TIMEOUT_BITS = 20
) (
    input  logic clock,
    input  logic not_reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    // The count equals cycles already spent, so the final cycle sees all-ones minus one.
    localparam logic [TIMEOUT_BITS-1:0] LAST_COUNT = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

    logic [TIMEOUT_BITS-1:0] count;

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TIMEOUT_BITS'(1);
        end
    end

    assign terminal = enable && (count == LAST_COUNT);

endmodule

// File: rtl/phase_sequencer.sv
// Top-level controller: sequences box filter then threshold, arbitrates the
// image ROM port and guards each phase. Build option CONTINUOUS_EN: free-running frames.
module phase_sequencer
    import phase_pkg::*;
#(
    parameter int WIDTH_BITS   = DEFAULT_WIDTH_BITS,
    parameter int HEIGHT_BITS  = DEFAULT_HEIGHT_BITS,
    parameter int C_BITS       = DEFAULT_C_BITS,
    parameter int TIMEOUT_BITS = DEFAULT_TIMEOUT_BITS
) (
    input  logic              clock,
    input  logic              not_reset,
    input  logic              iRestart,
    input  logic [C_BITS-1:0] iC,
    output logic [C_BITS-1:0] oC,
    phase_sequencer_if.master engine,
    output logic [2:0]        oState,
    output logic              oBusy,
    output logic              oError,
    output logic [7:0]        oFrameCount,
    output logic [C_BITS+4:0] oLedr
);

    phaseState_t state;
    phaseState_t nextState;
    logic        pending;
    logic        timeout;
    logic        stateChange;
    logic        leavingFinal;
    logic        boxStartPulse;
    logic        thrStartPulse;

    logic [WIDTH_BITS-1:0]  imageCol;
    logic [HEIGHT_BITS-1:0] imageRow;

    // NOTE: every variable written here gets a default first so no path infers a latch.
    always_comb begin
        nextState = state;
        case (state)
            STATE_IDLE:      nextState = STATE_BOX_START;
            STATE_BOX_START: nextState = STATE_BOX_RUN;
            STATE_BOX_RUN: begin
                if (engine.iBoxDone)  nextState = STATE_THR_START;
                else if (timeout)     nextState = STATE_ERROR;
            end
            STATE_THR_START: nextState = STATE_THR_RUN;
            STATE_THR_RUN: begin
                if (engine.iThrDone)  nextState = STATE_DONE;
                else if (timeout)     nextState = STATE_ERROR;
            end
            STATE_DONE: begin
`ifdef CONTINUOUS_EN
                nextState = STATE_IDLE;
`else
                if (iRestart || pending) nextState = STATE_IDLE;
`endif
            end
            STATE_ERROR: begin
                if (iRestart || pending) nextState = STATE_IDLE;
            end
            default:         nextState = STATE_IDLE;
        endcase
    end

    assign stateChange  = (nextState != state);
    assign leavingFinal = ((state == STATE_DONE) || (state == STATE_ERROR)) &&
                          (nextState == STATE_IDLE);

    phase_watchdog #(
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) watchdog (
        .clock     (clock),
        .not_reset (not_reset),
        .clear     (stateChange),
        .enable    (isRunState(state)),
        .terminal  (timeout)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            state         <= STATE_IDLE;
            pending       <= 1'b0;
            oError        <= 1'b0;
            oFrameCount   <= 8'd0;
            boxStartPulse <= 1'b0;
            thrStartPulse <= 1'b0;
        end else begin
            state         <= nextState;
            boxStartPulse <= (nextState == STATE_BOX_START);
            thrStartPulse <= (nextState == STATE_THR_START);

            if ((state == STATE_THR_RUN) && engine.iThrDone) begin
                oFrameCount <= oFrameCount + 8'd1;
            end

            // A restart mid-frame is remembered rather than aborting the frame.
            if (leavingFinal) begin
                pending <= 1'b0;
            end else if (isActive(state) && iRestart) begin
                pending <= 1'b1;
            end

            if (leavingFinal) begin
                oError <= 1'b0;
            end else if (nextState == STATE_ERROR) begin
                oError <= 1'b1;
            end
        end
    end

    // NOTE: the reset value is the live switch input, so oC tracks iC while reset is held.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            oC <= iC;
        end else if (state == STATE_IDLE) begin
            oC <= iC;
        end
    end

    // Arbitration decodes the registered state only, so the address never depends on done inputs.
    assign imageCol = isThrPhase(state) ? engine.iThrCol : engine.iBoxCol;
    assign imageRow = isThrPhase(state) ? engine.iThrRow : engine.iBoxRow;

    assign engine.oImageCol = imageCol;
    assign engine.oImageRow = imageRow;
    assign engine.oBoxStart = boxStartPulse;
    assign engine.oThrStart = thrStartPulse;

    assign oState = state;
    assign oBusy  = isActive(state);
    assign oLedr  = {oC, ledStatus(state)};

endmodule
